// File: rtl/alu_uart_pkg.sv
// Shared types and default parameters for the ALU/UART frame sequencer.
package alu_uart_pkg;

  localparam int unsigned DefDataW   = 8;
  localparam int unsigned DefOpcodeW = 6;
  localparam int unsigned DefTimeout = 50000;
  localparam int unsigned DefCountW  = 8;

  typedef enum logic [2:0] {
    StIdle,
    StGetB,
    StGetOp,
    StExec,
    StSend
  } state_e;

endpackage

// File: rtl/alu_uart_sequencer_if.sv
// Bundle of RX FIFO, TX FIFO, ALU and status signals around the frame sequencer.
interface alu_uart_sequencer_if
  import alu_uart_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned OPCODE_W = DefOpcodeW,
  parameter int unsigned COUNT_W  = DefCountW
);
  logic [DATA_W-1:0]   i_rx_data;
  logic                i_rx_empty;
  logic                o_rx_rd;
  logic                i_tx_full;
  logic [DATA_W-1:0]   o_tx_data;
  logic                o_tx_wr;
  logic [DATA_W-1:0]   o_op_a;
  logic [DATA_W-1:0]   o_op_b;
  logic [OPCODE_W-1:0] o_opcode;
  logic [DATA_W-1:0]   i_alu_result;
  logic                o_busy;
  logic                o_timeout;
  logic [COUNT_W-1:0]  o_frame_cnt;

  modport master (
    input  i_rx_data, i_rx_empty, i_tx_full, i_alu_result,
    output o_rx_rd, o_tx_data, o_tx_wr, o_op_a, o_op_b, o_opcode, o_busy, o_timeout,
           o_frame_cnt
  );

  modport slave (
    output i_rx_data, i_rx_empty, i_tx_full, i_alu_result,
    input  o_rx_rd, o_tx_data, o_tx_wr, o_op_a, o_op_b, o_opcode, o_busy, o_timeout,
           o_frame_cnt
  );
endinterface

// File: rtl/uart_timeout_counter.sv
// Inter-byte timeout counter: counts enabled cycles, pulses expire on the last one.
module uart_timeout_counter #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int unsigned CntW = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] Last = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] cnt_q;

  assign expire = enable && (cnt_q == Last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear || expire) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end
endmodule

// File: rtl/alu_uart_sequencer.sv
// Collects A, B, opcode bytes from the RX FIFO, runs them through an external ALU
// and pushes the one-byte result to the TX FIFO.
module alu_uart_sequencer
  import alu_uart_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned OPCODE_W = DefOpcodeW,
  parameter int unsigned TIMEOUT  = DefTimeout,
  parameter int unsigned COUNT_W  = DefCountW
) (
  input logic                  clk,
  input logic                  reset,
  alu_uart_sequencer_if.master bus
);
  if (OPCODE_W > DATA_W) begin : g_bad_opcode_w
    $error("OPCODE_W must not exceed DATA_W");
  end
  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   op_a_q, op_b_q, result_q;
  logic [OPCODE_W-1:0] opcode_q;
  logic [COUNT_W-1:0]  frame_cnt_q;
  logic                rx_rd_q, rx_rd_d;
  logic                tx_wr_q, tx_wr_d;
  logic                timeout_q, timeout_d;
  logic                byte_ok, tmo_enable, tmo_expire;

  // The pop strobe is registered, so during its cycle the FIFO head is still the old byte.
  assign byte_ok    = !bus.i_rx_empty && !rx_rd_q;
  assign tmo_enable = (state_q inside {StGetB, StGetOp}) && !byte_ok;

  uart_timeout_counter #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (rx_rd_d),
    .enable(tmo_enable),
    .expire(tmo_expire)
  );

  always_comb begin
    state_d   = state_q;
    rx_rd_d   = 1'b0;
    tx_wr_d   = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (byte_ok) begin
          rx_rd_d = 1'b1;
          state_d = StGetB;
        end
      end
      StGetB, StGetOp: begin
        if (byte_ok) begin
          rx_rd_d = 1'b1;
          state_d = (state_q == StGetB) ? StGetOp : StExec;
        end else if (tmo_expire) begin
          timeout_d = 1'b1;
          state_d   = StIdle;
        end
      end
      StExec: state_d = StSend;
      StSend: begin
        if (!bus.i_tx_full) begin
          tx_wr_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      rx_rd_q     <= 1'b0;
      tx_wr_q     <= 1'b0;
      timeout_q   <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      opcode_q    <= '0;
      result_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rx_rd_q   <= rx_rd_d;
      tx_wr_q   <= tx_wr_d;
      timeout_q <= timeout_d;
      if (rx_rd_d && (state_q == StIdle))  op_a_q   <= bus.i_rx_data;
      if (rx_rd_d && (state_q == StGetB))  op_b_q   <= bus.i_rx_data;
      if (rx_rd_d && (state_q == StGetOp)) opcode_q <= bus.i_rx_data[OPCODE_W-1:0];
      if (state_q == StExec) result_q <= bus.i_alu_result;
      if (tx_wr_d) frame_cnt_q <= frame_cnt_q + COUNT_W'(1);
    end
  end

  assign bus.o_rx_rd     = rx_rd_q;
  assign bus.o_tx_wr     = tx_wr_q;
  assign bus.o_tx_data   = result_q;
  assign bus.o_timeout   = timeout_q;
  assign bus.o_op_a      = op_a_q;
  assign bus.o_op_b      = op_b_q;
  assign bus.o_opcode    = opcode_q;
  assign bus.o_frame_cnt = frame_cnt_q;
  assign bus.o_busy      = (state_q != StIdle);
endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Scoreboard bench: FIFO models around the sequencer, expected results queued per frame.
module tb_alu_uart_sequencer;
  localparam int unsigned DW = 8;
  localparam int unsigned OW = 6;
  localparam int unsigned TO = 16;
  localparam int unsigned CW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_uart_sequencer_if #(.DATA_W(DW), .OPCODE_W(OW), .COUNT_W(CW)) bus ();

  alu_uart_sequencer #(
    .DATA_W  (DW),
    .OPCODE_W(OW),
    .TIMEOUT (TO),
    .COUNT_W (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int rd_count = 0, wr_count = 0, tmo_count = 0;
  int last_wr_cyc = -1, last_tmo_cyc = -1;
  int mdl_cnt = 0;
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] sb[$];
  int cnt_log[$];

  function automatic logic [DW-1:0] alu(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic [OW-1:0] op);
    case (op)
      6'h20:   return a + b;
      6'h22:   return a - b;
      6'h24:   return a & b;
      6'h25:   return a | b;
      6'h26:   return a ^ b;
      default: return a;
    endcase
  endfunction

  always_comb bus.i_alu_result = alu(bus.o_op_a, bus.o_op_b, bus.o_opcode);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // RX FIFO pops on the edge that ends the strobe cycle.
  always @(posedge clk) begin
    cyc++;
    if (bus.o_rx_rd) begin
      rd_count++;
      check("rd_nonempty", rx_q.size() != 0, 1);
      if (rx_q.size() != 0) void'(rx_q.pop_front());
    end
  end

  always @(negedge clk) begin
    bus.i_rx_empty = (rx_q.size() == 0);
    bus.i_rx_data  = (rx_q.size() != 0) ? rx_q[0] : '0;
    if (bus.o_tx_wr) begin
      wr_count++;
      last_wr_cyc = cyc;
      mdl_cnt = (mdl_cnt + 1) % (1 << CW);
      cnt_log.push_back(int'(bus.o_frame_cnt));
      check("tx_pending", sb.size() != 0, 1);
      if (sb.size() != 0) check("tx_data", bus.o_tx_data, sb.pop_front());
      check("frame_cnt", bus.o_frame_cnt, mdl_cnt);
    end
    if (bus.o_timeout) begin
      tmo_count++;
      last_tmo_cyc = cyc;
      check("busy_on_timeout", bus.o_busy, 0);
    end
  end

  task automatic push_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
    rx_q.push_back(a);
    rx_q.push_back(b);
    rx_q.push_back(op);
    sb.push_back(alu(a, b, op[OW-1:0]));
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((sb.size() != 0 || rx_q.size() != 0 || bus.o_busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_reached", n < budget, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"}, bus.o_busy, 0);
    check({tag, "_rx_rd"}, bus.o_rx_rd, 0);
    check({tag, "_tx_wr"}, bus.o_tx_wr, 0);
    check({tag, "_timeout"}, bus.o_timeout, 0);
    check({tag, "_op_a"}, bus.o_op_a, 0);
    check({tag, "_op_b"}, bus.o_op_b, 0);
    check({tag, "_opcode"}, bus.o_opcode, 0);
    check({tag, "_tx_data"}, bus.o_tx_data, 0);
    check({tag, "_frame_cnt"}, bus.o_frame_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=cycle%0d exp=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rd0, wr0, t0, p, drop;
    int exp_seq[5];
    exp_seq = '{1, 2, 3, 0, 1};
    bus.i_rx_empty = 1'b1;
    bus.i_rx_data  = '0;
    bus.i_tx_full  = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;

    // Basic ADD frame
    @(posedge clk); #1;
    rd0 = rd_count; wr0 = wr_count;
    push_frame(8'h05, 8'h03, 8'h20);
    wait_idle(40);
    check("f1_rd", rd_count - rd0, 3);
    check("f1_wr", wr_count - wr0, 1);
    check("f1_data", bus.o_tx_data, 8'h08);
    check("f1_cnt", bus.o_frame_cnt, 1);

    // TX full for 10 cycles after SEND entry
    @(posedge clk); #1;
    bus.i_tx_full = 1'b1;
    wr0 = wr_count;
    push_frame(8'h05, 8'h03, 8'h20);
    repeat (16) @(posedge clk);
    #1;
    check("full_no_wr", wr_count - wr0, 0);
    check("full_busy", bus.o_busy, 1);
    check("full_data", bus.o_tx_data, 8'h08);
    drop = cyc;
    bus.i_tx_full = 1'b0;
    wait_idle(20);
    check("full_wr_once", wr_count - wr0, 1);
    check("full_wr_cyc", last_wr_cyc, drop + 1);

    // A only, then silence: timeout 16 cycles after GET_B entry
    @(posedge clk); #1;
    t0 = tmo_count; p = cyc;
    rx_q.push_back(8'h11);
    repeat (20) @(posedge clk);
    #1;
    check("tmo_count", tmo_count - t0, 1);
    check("tmo_cyc", last_tmo_cyc, p + 17);
    check("tmo_idle", bus.o_busy, 0);
    check("tmo_keep_a", bus.o_op_a, 8'h11);
    check("tmo_keep_b", bus.o_op_b, 8'h03);
    push_frame(8'h40, 8'h02, 8'h22);
    wait_idle(40);

    // B lands on the expiry cycle: consumed, no timeout
    @(posedge clk); #1;
    t0 = tmo_count; p = cyc;
    rx_q.push_back(8'h21);
    while (cyc < p + 16) begin
      @(posedge clk);
      #1;
    end
    rx_q.push_back(8'h07);
    @(posedge clk); #1;
    check("edge_busy", bus.o_busy, 1);
    check("edge_op_b", bus.o_op_b, 8'h07);
    check("edge_no_tmo", tmo_count - t0, 0);
    rx_q.push_back(8'h24);
    sb.push_back(alu(8'h21, 8'h07, 6'h24));
    wait_idle(40);
    check("edge_no_tmo_end", tmo_count - t0, 0);

    // Reset while waiting for the opcode
    @(posedge clk); #1;
    wr0 = wr_count;
    rx_q.push_back(8'h09);
    rx_q.push_back(8'h04);
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_busy", bus.o_busy, 1);
    reset = 1'b1;
    mdl_cnt = 0;
    #1;
    check_reset_values("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_no_wr", wr_count - wr0, 0);
    push_frame(8'h09, 8'h04, 8'h25);
    wait_idle(40);
    check("midrst_wr", wr_count - wr0, 1);
    check("midrst_cnt", bus.o_frame_cnt, 1);

    // Five back-to-back frames with a fresh counter; wraps at 2^COUNT_W
    @(posedge clk); #1;
    reset = 1'b1;
    mdl_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b0;
    cnt_log.delete();
    push_frame(8'h05, 8'h03, 8'h20);
    push_frame(8'h10, 8'h01, 8'h22);
    push_frame(8'hF0, 8'h3C, 8'h24);
    push_frame(8'h81, 8'h42, 8'h25);
    push_frame(8'hAA, 8'h0F, 8'hE6);
    wait_idle(120);
    check("seq_len", cnt_log.size(), 5);
    for (int i = 0; i < 5; i++) begin
      check("cnt_seq", (i < cnt_log.size()) ? cnt_log[i] : 32'hFF, exp_seq[i]);
    end
    check("xor_upper_ignored", bus.o_tx_data, 8'hA5);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
